// File: rtl/uart_buf_pkg.sv
// -----------------------------------------------------------------------------
// uart_buf_pkg
// Shared definitions for the UART buffering bridge:
//   - default byte width and FIFO depths (log2)
//   - TX drain FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package uart_buf_pkg;

   localparam int UART_NB_DATA_DEF       = 8;
   localparam int UART_RX_DEPTH_LOG2_DEF = 4;
   localparam int UART_TX_DEPTH_LOG2_DEF = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } tx_state_t;

endpackage : uart_buf_pkg

// File: rtl/uart_buffer_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_buffer_bridge_if
// Bundles every non-clock signal of the bridge.
//   master modport : the debug unit + UART PHY side (drives i_*, observes o_*)
//   slave  modport : the bridge itself (observes i_*, drives o_*)
// Signals:
//   i_rd / i_wr / i_wdata / i_tx_start       debug-unit handshake into bridge
//   o_rx_data / o_rx_done / o_tx_done        bridge status back to debug unit
//   i_phy_rx_data / i_phy_rx_done            RX shifter byte + strobe
//   o_phy_tx_data / o_phy_tx_start           byte + start to TX shifter
//   i_phy_tx_done                            TX shifter finished strobe
//   i_clr_status / o_rx_ovf / o_tx_ovf       sticky overflow status
// -----------------------------------------------------------------------------
interface uart_buffer_bridge_if
   import uart_buf_pkg::*;
#(
   parameter int NB_UART_DATA = UART_NB_DATA_DEF
);

   logic                    i_rd;
   logic                    i_wr;
   logic [NB_UART_DATA-1:0] i_wdata;
   logic                    i_tx_start;
   logic [NB_UART_DATA-1:0] o_rx_data;
   logic                    o_rx_done;
   logic                    o_tx_done;
   logic [NB_UART_DATA-1:0] i_phy_rx_data;
   logic                    i_phy_rx_done;
   logic [NB_UART_DATA-1:0] o_phy_tx_data;
   logic                    o_phy_tx_start;
   logic                    i_phy_tx_done;
   logic                    i_clr_status;
   logic                    o_rx_ovf;
   logic                    o_tx_ovf;

   modport master (
      output i_rd, i_wr, i_wdata, i_tx_start,
      output i_phy_rx_data, i_phy_rx_done, i_phy_tx_done, i_clr_status,
      input  o_rx_data, o_rx_done, o_tx_done,
      input  o_phy_tx_data, o_phy_tx_start, o_rx_ovf, o_tx_ovf
   );

   modport slave (
      input  i_rd, i_wr, i_wdata, i_tx_start,
      input  i_phy_rx_data, i_phy_rx_done, i_phy_tx_done, i_clr_status,
      output o_rx_data, o_rx_done, o_tx_done,
      output o_phy_tx_data, o_phy_tx_start, o_rx_ovf, o_tx_ovf
   );

endinterface : uart_buffer_bridge_if

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, i_rst_n : clock, asynchronous active-low reset
//   push, wdata  : write request and data (dropped when full unless popping)
//   pop          : remove head (ignored when empty)
//   rdata        : current head, forced to 0 while empty
//   full, empty  : occupancy flags
//   count        : entries held, 0..2**DEPTH_LOG2
//   drop         : one-cycle pulse when a push was discarded
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  drop
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   cnt;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;

   // A pop frees the head slot in the same edge, so a push at full still lands
   // when paired with a pop. A pop on empty is ignored, so push+pop on empty is
   // a plain push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & ~do_push;

   // Empty FIFO presents 0 so the head output is defined straight out of reset.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; validity is tracked by cnt, and leaving the
   // array unreset lets it map onto plain flops/RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : uart_sync_fifo

// File: rtl/uart_buffer_bridge.sv
// -----------------------------------------------------------------------------
// uart_buffer_bridge
// Byte-buffering bridge between the debug unit's UART handshake and the
// bit-level UART PHY.
//   clk      : system clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : uart_buffer_bridge_if.slave (see interface header for signals)
// RX path: PHY bytes land in an RX FIFO; the debug unit pops with i_rd and sees
//          the head (FWFT) on o_rx_data, o_rx_done = FIFO non-empty.
// TX path: i_wr queues bytes; i_tx_start kicks a drain FSM that hands bytes to
//          the PHY one at a time and pulses o_tx_done when the queue runs dry.
// Option macro UART_BUF_OVF_STATUS_EN: when defined, o_rx_ovf / o_tx_ovf are
//   sticky drop flags cleared by i_clr_status (set wins); otherwise both are 0
//   and i_clr_status is unused.
// -----------------------------------------------------------------------------
module uart_buffer_bridge
   import uart_buf_pkg::*;
#(
   parameter int NB_UART_DATA  = UART_NB_DATA_DEF,
   parameter int RX_DEPTH_LOG2 = UART_RX_DEPTH_LOG2_DEF,
   parameter int TX_DEPTH_LOG2 = UART_TX_DEPTH_LOG2_DEF
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   uart_buffer_bridge_if.slave  bus
);

   // ---------------------------------------------------------------- RX FIFO
   logic [NB_UART_DATA-1:0] rx_head;
   logic                    rx_full;
   logic                    rx_empty;
   logic [RX_DEPTH_LOG2:0]  rx_count;
   logic                    rx_drop;

   uart_sync_fifo #(
      .WIDTH      (NB_UART_DATA),
      .DEPTH_LOG2 (RX_DEPTH_LOG2)
   ) u_rx_fifo (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .push    (bus.i_phy_rx_done),
      .wdata   (bus.i_phy_rx_data),
      .pop     (bus.i_rd),
      .rdata   (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count),
      .drop    (rx_drop)
   );

   assign bus.o_rx_data = rx_head;
   assign bus.o_rx_done = ~rx_empty;

   // ---------------------------------------------------------------- TX FIFO
   logic [NB_UART_DATA-1:0] tx_head;
   logic                    tx_full;
   logic                    tx_empty;
   logic [TX_DEPTH_LOG2:0]  tx_count;
   logic                    tx_drop;
   logic                    tx_pop;

   uart_sync_fifo #(
      .WIDTH      (NB_UART_DATA),
      .DEPTH_LOG2 (TX_DEPTH_LOG2)
   ) u_tx_fifo (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .push    (bus.i_wr),
      .wdata   (bus.i_wdata),
      .pop     (tx_pop),
      .rdata   (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count),
      .drop    (tx_drop)
   );

   // ------------------------------------------------------------ TX drain FSM
   tx_state_t               state_q;
   tx_state_t               state_d;
   logic                    phy_tx_start;
   logic                    tx_done;
   logic [NB_UART_DATA-1:0] phy_tx_data_q;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.i_tx_start)    state_d = tx_empty ? DONE : LOAD;
         LOAD:                        state_d = SEND;
         SEND:                        state_d = WAIT;
         WAIT: if (bus.i_phy_tx_done) state_d = tx_empty ? DONE : LOAD;
         DONE:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Outputs decode the state register only: no input reaches them
   // combinationally.
   always_comb begin
      tx_pop       = 1'b0;
      phy_tx_start = 1'b0;
      tx_done      = 1'b0;
      case (state_q)
         LOAD:    tx_pop       = 1'b1;
         SEND:    phy_tx_start = 1'b1;
         DONE:    tx_done      = 1'b1;
         default: ;
      endcase
   end

   // Byte handed to the TX shifter; held stable through SEND and WAIT.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)    phy_tx_data_q <= '0;
      else if (tx_pop) phy_tx_data_q <= tx_head;
   end

   assign bus.o_phy_tx_data  = phy_tx_data_q;
   assign bus.o_phy_tx_start = phy_tx_start;
   assign bus.o_tx_done      = tx_done;

   // ------------------------------------------------------- overflow status
`ifdef UART_BUF_OVF_STATUS_EN
   logic rx_ovf_q;
   logic tx_ovf_q;

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
      end else begin
         if (rx_drop)               rx_ovf_q <= 1'b1;
         else if (bus.i_clr_status) rx_ovf_q <= 1'b0;
         if (tx_drop)               tx_ovf_q <= 1'b1;
         else if (bus.i_clr_status) tx_ovf_q <= 1'b0;
      end
   end

   assign bus.o_rx_ovf = rx_ovf_q;
   assign bus.o_tx_ovf = tx_ovf_q;
`else
   assign bus.o_rx_ovf = 1'b0;
   assign bus.o_tx_ovf = 1'b0;

   logic unused_ovf;
   assign unused_ovf = ^{bus.i_clr_status, rx_drop, tx_drop};
`endif

   // Occupancy details the bridge does not consume.
   logic unused_fifo;
   assign unused_fifo = ^{rx_count, tx_count, rx_full, tx_full};

endmodule : uart_buffer_bridge

// File: doc/uart_buffer_bridge.md
# uart_buffer_bridge

Byte-buffering bridge between `cpu_subsystem`'s UART handshake (`o_uart_tx_start`, `o_uart_rd`, `o_uart_wr`, `o_uart_wdata`, `i_uart_rx_data`, `i_uart_rx_done`, `i_uart_tx_done`) and the bit-level UART PHY (baud generator, RX and TX shifters).
- RX FIFO absorbs PHY receive bursts while the debug unit is busy.
- TX FIFO queues debug-unit bytes; a drain FSM feeds them to the PHY one at a time and reports burst completion.

## Interface
Parameters:
- `NB_UART_DATA`, 8, byte width.
- `RX_DEPTH_LOG2`, 4, log2 of RX FIFO entries (16).
- `TX_DEPTH_LOG2`, 4, log2 of TX FIFO entries (16).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_rd`  in  1  pop RX FIFO head (from `o_uart_rd`).
- `i_wr`  in  1  push `i_wdata` into TX FIFO (from `o_uart_wr`).
- `i_wdata`  in  NB_UART_DATA  TX byte.
- `i_tx_start`  in  1  start draining TX FIFO (from `o_uart_tx_start`).
- `o_rx_data`  out  NB_UART_DATA  RX FIFO head, first-word-fall-through.
- `o_rx_done`  out  1  level, RX FIFO non-empty.
- `o_tx_done`  out  1  one-cycle pulse, burst drained.
- `i_phy_rx_data`  in  NB_UART_DATA  byte from RX shifter.
- `i_phy_rx_done`  in  1  one-cycle pulse, byte received.
- `o_phy_tx_data`  out  NB_UART_DATA  byte to TX shifter.
- `o_phy_tx_start`  out  1  one-cycle pulse, start TX shifter.
- `i_phy_tx_done`  in  1  one-cycle pulse, TX shifter finished.
- `i_clr_status`  in  1  clear sticky overflow flags.
- `o_rx_ovf`  out  1  sticky RX overflow.
- `o_tx_ovf`  out  1  sticky TX overflow.

## Operation
- **RX path:** `i_phy_rx_done` pushes `i_phy_rx_data`; `i_rd` pops.
  - Push when full: new byte dropped.
  - Pop when empty: ignored.
  - Simultaneous push and pop when full: both occur, count unchanged.
  - Simultaneous push and pop when empty: push only.
- **TX path:** `i_wr` pushes; write when full is dropped. The FIFO is popped only by the FSM.
- Pointers are RX_DEPTH_LOG2/TX_DEPTH_LOG2 bits wide and wrap modulo depth. Counts are one bit wider (range 0..depth).
- **TX FSM states:**
  - `IDLE`: on `i_tx_start`, go to `LOAD` if TX non-empty, else `DONE`.
  - `LOAD`: pop head into `o_phy_tx_data` register, go to `SEND`.
  - `SEND`: `o_phy_tx_start`=1 for this cycle, go to `WAIT`.
  - `WAIT`: on `i_phy_tx_done`, go to `LOAD` if TX non-empty, else `DONE`.
  - `DONE`: `o_tx_done`=1 for this cycle, go to `IDLE`.
- `i_tx_start` outside `IDLE` is ignored. Bytes written during a burst are sent in the same burst.
- `i_phy_tx_done` outside `WAIT` is ignored.

## Timing
- Reset values (async, all at once): FIFOs empty, FSM `IDLE`, and every output 0 (`o_rx_data`, `o_rx_done`, `o_tx_done`, `o_phy_tx_data`, `o_phy_tx_start`, `o_rx_ovf`, `o_tx_ovf`).
- Reset mid-burst abandons queued and in-flight bytes; a late `i_phy_tx_done` is ignored.
- `i_phy_rx_done` at cycle n into an empty FIFO: `o_rx_done`=1 and `o_rx_data` valid at n+1.
- `i_rd` at cycle n: new head (or `o_rx_done`=0) visible at n+1.
- `i_tx_start` at n with TX non-empty: `LOAD` at n+1, `o_phy_tx_start` at n+2.
- `i_tx_start` at n with TX empty: `o_tx_done` at n+1.
- `i_phy_tx_done` at m:
  - next `o_phy_tx_start` at m+2 if more bytes are queued;
  - otherwise `o_tx_done` at m+1.
- A TX write at cycle n is visible to the FSM's empty check at n+1.
- All outputs are registered or decoded directly from state registers; no input-to-output combinational path.

## Configuration
- Macro `UART_BUF_OVF_STATUS_EN`.
- **Defined:**
  - `o_rx_ovf` sets on a dropped RX push; `o_tx_ovf` sets on a dropped TX write.
  - Both flags are sticky until `i_clr_status`.
  - Set and clear in the same cycle: set wins.
- **Undefined:**
  - Flag logic not compiled; `o_rx_ovf`/`o_tx_ovf` tied to 0.
  - `i_clr_status` unused.
  - Drops are silent.
  - Port list is identical either way.

## Structure
- Shared package/header `uart_buf_pkg` holds:
  - FSM state encoding: `IDLE`, `LOAD`, `SEND`, `WAIT`, `DONE` (3 bits);
  - default depth constants;
  - `NB_UART_DATA` default.
- One sub-module `uart_sync_fifo` (parameterised width/depth, FWFT, full/empty/count), instantiated twice.
- The TX FSM and overflow flags live in the top.

## Test plan
- **RX buffering:** reset, 3 PHY RX pulses 0x11/0x22/0x33 with no reads → `o_rx_done`=1 and head 0x11; 3 reads yield 0x11, 0x22, 0x33, then `o_rx_done`=0.
- **RX overflow:** 17 RX pulses into 16-entry FIFO → 16 bytes retained, 17th lost; `o_rx_ovf`=1 with macro, 0 without; `i_clr_status` clears it.
- **TX burst:** write 0xA5, 0x5A, then `i_tx_start` at n → `o_phy_tx_start` at n+2 with 0xA5; `i_phy_tx_done` at m → 0x5A start at m+2; second done at k → `o_tx_done` at k+1 only.
- **Empty start and append:**
  - `i_tx_start` with empty TX → `o_tx_done` next cycle, no PHY start.
  - A write during `WAIT` of a 1-byte burst → that byte sent before `o_tx_done`.
- **Boundaries:**
  - Simultaneous RX push and pop at full → count stays 16, order preserved.
  - `i_tx_start` in `WAIT` → ignored.
- **Reset mid-burst:** assert `i_rst_n`=0 in `WAIT` with 3 bytes queued → all outputs 0 immediately, FIFOs empty; a late `i_phy_tx_done` after release produces no `o_phy_tx_start` or `o_tx_done`.
